// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB completion arbiter.
// Holding-register field widths are fixed here; cdb_arbiter's PREG_W/ROB_W defaults follow them.
package cdb_arbiter_pkg;

    localparam int CDB_SLOTS  = 3;
    localparam int CDB_PREG_W = 7;
    localparam int CDB_ROB_W  = 5;

    localparam int REQ_ALU0 = 0;
    localparam int REQ_ALU1 = 1;
    localparam int REQ_BR   = 2;
    localparam int REQ_LSU  = 3;

    typedef struct packed {
        logic [CDB_PREG_W-1:0] preg;
        logic                  has_dest;
        logic [CDB_ROB_W-1:0]  rob_tag;
    } cdb_req_t;

    // Physical register 0 is never a real producer, so it never wakes anything up.
    function automatic logic preg_wakes(cdb_req_t r);
        return r.has_dest && (r.preg != '0);
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick3.sv
// Combinational rotating scan: grants up to CDB_SLOTS occupied entries starting at rr_ptr,
// filling slots in scan order, and reports the pointer just past the last grant.
module rr_pick3
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]                occ,
    input  logic [PTR_W-1:0]                  rr_ptr,
    output logic [NUM_REQ-1:0]                grant,
    output logic [CDB_SLOTS-1:0]              slot_vld,
    output logic [CDB_SLOTS-1:0][PTR_W-1:0]   slot_idx,
    output logic [PTR_W-1:0]                  next_ptr
);

    localparam logic [1:0] SLOTS = 2'(CDB_SLOTS);

    int               idx;
    logic [PTR_W-1:0] cur;
    logic [1:0]       n;

    always_comb begin
        grant    = '0;
        slot_vld = '0;
        slot_idx = '0;
        next_ptr = rr_ptr;
        idx      = 0;
        cur      = '0;
        n        = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cur = PTR_W'(idx);
            if (occ[cur] && (n < SLOTS)) begin
                grant[cur]  = 1'b1;
                slot_vld[n] = 1'b1;
                slot_idx[n] = cur;
                n           = n + 2'd1;
                next_ptr    = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding register per completion requester, up to three
// round-robin grants per cycle, registered broadcast. Optional counters: CDB_PERF_CNT_EN.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PREG_W  = CDB_PREG_W,
    parameter int ROB_W   = CDB_ROB_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mispredict,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*PREG_W-1:0] req_preg,
    input  logic [NUM_REQ-1:0]      req_has_dest,
    input  logic [NUM_REQ*ROB_W-1:0] req_rob_tag,
    output logic [PREG_W-1:0]       preg1_rdy,
    output logic [PREG_W-1:0]       preg2_rdy,
    output logic [PREG_W-1:0]       preg3_rdy,
    output logic                    preg1_valid,
    output logic                    preg2_valid,
    output logic                    preg3_valid,
    output logic [2:0]              rob_done_valid,
    output logic [3*ROB_W-1:0]      rob_done_tag,
    output logic                    busy
`ifdef CDB_PERF_CNT_EN
   ,output logic [31:0]             perf_grant_cnt,
    output logic [31:0]             perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                   occ_q, occ_d;
    cdb_req_t                             hold_q [NUM_REQ];
    cdb_req_t                             hold_d [NUM_REQ];
    logic [PTR_W-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [CDB_SLOTS-1:0][PREG_W-1:0]     slot_preg_q, slot_preg_d;
    logic [CDB_SLOTS-1:0]                 slot_pvld_q, slot_pvld_d;
    logic [CDB_SLOTS-1:0]                 done_vld_q, done_vld_d;
    logic [CDB_SLOTS-1:0][ROB_W-1:0]      done_tag_q, done_tag_d;

    logic [NUM_REQ-1:0]                   grant;
    logic [NUM_REQ-1:0]                   accept;
    logic [CDB_SLOTS-1:0]                 slot_vld;
    logic [CDB_SLOTS-1:0][PTR_W-1:0]      slot_idx;
    logic [PTR_W-1:0]                     next_ptr;
    cdb_req_t                             sel;

    rr_pick3 #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .occ      (occ_q),
        .rr_ptr   (rr_ptr_q),
        .grant    (grant),
        .slot_vld (slot_vld),
        .slot_idx (slot_idx),
        .next_ptr (next_ptr)
    );

    // A granted entry frees its register this cycle, so it may be refilled immediately.
    always_comb begin
        req_ready = (reset || mispredict) ? '0 : (~occ_q | grant);
        accept    = req_valid & req_ready;
        occ_d     = mispredict ? '0 : (accept | (occ_q & ~grant));
        for (int i = 0; i < NUM_REQ; i++) begin
            hold_d[i] = hold_q[i];
            if (accept[i]) begin
                hold_d[i].preg     = req_preg[i*PREG_W +: PREG_W];
                hold_d[i].has_dest = req_has_dest[i];
                hold_d[i].rob_tag  = req_rob_tag[i*ROB_W +: ROB_W];
            end
        end
        rr_ptr_d = mispredict ? rr_ptr_q : next_ptr;
    end

    // Grants made in a flush cycle are dropped rather than broadcast.
    always_comb begin
        slot_preg_d = '0;
        slot_pvld_d = '0;
        done_vld_d  = '0;
        done_tag_d  = '0;
        sel         = '0;
        for (int k = 0; k < CDB_SLOTS; k++) begin
            if (slot_vld[k] && !mispredict) begin
                sel            = hold_q[slot_idx[k]];
                slot_preg_d[k] = sel.preg;
                slot_pvld_d[k] = preg_wakes(sel);
                done_vld_d[k]  = 1'b1;
                done_tag_d[k]  = sel.rob_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q       <= '0;
            rr_ptr_q    <= '0;
            slot_preg_q <= '0;
            slot_pvld_q <= '0;
            done_vld_q  <= '0;
            done_tag_q  <= '0;
        end else begin
            occ_q       <= occ_d;
            rr_ptr_q    <= rr_ptr_d;
            slot_preg_q <= slot_preg_d;
            slot_pvld_q <= slot_pvld_d;
            done_vld_q  <= done_vld_d;
            done_tag_q  <= done_tag_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign preg1_rdy      = slot_preg_q[0];
    assign preg2_rdy      = slot_preg_q[1];
    assign preg3_rdy      = slot_preg_q[2];
    assign preg1_valid    = slot_pvld_q[0];
    assign preg2_valid    = slot_pvld_q[1];
    assign preg3_valid    = slot_pvld_q[2];
    assign rob_done_valid = done_vld_q;
    assign rob_done_tag   = done_tag_q;
    assign busy           = |occ_q;

`ifdef CDB_PERF_CNT_EN
    logic [31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [1:0]  n_grants;

    // Counters see the arbiter's raw decisions and ignore flushes; both saturate.
    always_comb begin
        n_grants = '0;
        for (int k = 0; k < CDB_SLOTS; k++) begin
            n_grants = n_grants + 2'(slot_vld[k]);
        end
        grant_cnt_d = (grant_cnt_q > (32'hFFFF_FFFF - 32'(n_grants))) ? '1
                                                                      : grant_cnt_q + 32'(n_grants);
        stall_cnt_d = stall_cnt_q;
        if ((|(occ_q & ~grant)) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_grant_cnt = grant_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: scenario tasks push expected broadcasts to a queue,
// a negedge monitor pops and compares every non-empty broadcast cycle.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        mispredict;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [27:0] req_preg;
    logic [3:0]  req_has_dest;
    logic [19:0] req_rob_tag;
    logic [6:0]  preg1_rdy, preg2_rdy, preg3_rdy;
    logic        preg1_valid, preg2_valid, preg3_valid;
    logic [2:0]  rob_done_valid;
    logic [14:0] rob_done_tag;
    logic        busy;
`ifdef CDB_PERF_CNT_EN
    logic [31:0] perf_grant_cnt, perf_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  dv;
        logic [2:0]  pv;
        logic [20:0] preg;
        logic [14:0] tag;
    } bcast_t;

    bcast_t exp_q[$];
    bcast_t obs, exp_b;

    cdb_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .mispredict     (mispredict),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_preg       (req_preg),
        .req_has_dest   (req_has_dest),
        .req_rob_tag    (req_rob_tag),
        .preg1_rdy      (preg1_rdy),
        .preg2_rdy      (preg2_rdy),
        .preg3_rdy      (preg3_rdy),
        .preg1_valid    (preg1_valid),
        .preg2_valid    (preg2_valid),
        .preg3_valid    (preg3_valid),
        .rob_done_valid (rob_done_valid),
        .rob_done_tag   (rob_done_tag),
        .busy           (busy)
`ifdef CDB_PERF_CNT_EN
       ,.perf_grant_cnt (perf_grant_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic bcast_t mk(logic [2:0] dv, logic [2:0] pv,
                                  logic [6:0] p1, logic [6:0] p2, logic [6:0] p3,
                                  logic [4:0] t1, logic [4:0] t2, logic [4:0] t3);
        bcast_t b;
        b.dv   = dv;
        b.pv   = pv;
        b.preg = {p3, p2, p1};
        b.tag  = {t3, t2, t1};
        return b;
    endfunction

    // Every cycle carrying any broadcast content must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            obs.dv   = rob_done_valid;
            obs.pv   = {preg3_valid, preg2_valid, preg1_valid};
            obs.preg = {preg3_rdy, preg2_rdy, preg1_rdy};
            obs.tag  = rob_done_tag;
            if (obs !== '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_broadcast t=%0t got=%h expected none", $time, obs);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (obs !== exp_b) begin
                        failures++;
                        $display("[TB] FAIL broadcast t=%0t got=%h expected=%h", $time, obs, exp_b);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid    = '0;
        req_preg     = '0;
        req_has_dest = '0;
        req_rob_tag  = '0;
        mispredict   = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [6:0] p, input logic [4:0] t, input logic hd);
        req_valid[i]          = 1'b1;
        req_preg[i*7 +: 7]    = p;
        req_has_dest[i]       = hd;
        req_rob_tag[i*5 +: 5] = t;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        req_valid = 4'hF;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_ready got=%b expected=0000", req_ready);
        end
        step();
        step();
        @(negedge clk);
        checks++;
        if ({busy, rob_done_valid, preg1_valid, preg2_valid, preg3_valid} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs busy=%b dv=%b pv=%b%b%b expected all 0",
                     busy, rob_done_valid, preg1_valid, preg2_valid, preg3_valid);
        end
        step();
        reset = 1'b0;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'hF) begin
            failures++;
            $display("[TB] FAIL post_reset_ready got=%b expected=1111", req_ready);
        end
        step();
    endtask

    task automatic test_single();
        set_req(2, 7'h15, 5'd7, 1'b1);
        exp_q.push_back(mk(3'b001, 3'b001, 7'h15, 7'h0, 7'h0, 5'd7, 5'd0, 5'd0));
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rob_done_valid !== 3'b000) begin
            failures++;
            $display("[TB] FAIL single_grant_cycle busy=%b dv=%b expected busy=1 dv=000", busy, rob_done_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if (preg1_valid !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_latency preg1_valid=%b busy=%b expected 1 and 0", preg1_valid, busy);
        end
        // Pointer now sits at 3, so a full set of requests starts with the LSU.
        step();
        for (int i = 0; i < 4; i++) set_req(i, 7'(8'h50 + i), 5'(20 + i), 1'b1);
        exp_q.push_back(mk(3'b111, 3'b111, 7'h53, 7'h50, 7'h51, 5'd23, 5'd20, 5'd21));
        exp_q.push_back(mk(3'b001, 3'b001, 7'h52, 7'h0, 7'h0, 5'd22, 5'd0, 5'd0));
        step();
        clear_inputs();
        repeat (4) step();
    endtask

    task automatic test_four();
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 7'(8'h10 + i), 5'(10 + i), 1'b1);
        exp_q.push_back(mk(3'b111, 3'b111, 7'h10, 7'h11, 7'h12, 5'd10, 5'd11, 5'd12));
        exp_q.push_back(mk(3'b001, 3'b001, 7'h13, 7'h0, 7'h0, 5'd13, 5'd0, 5'd0));
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0111) begin
            failures++;
            $display("[TB] FAIL four_ready got=%b expected=0111", req_ready);
        end
        step();
        step();
`ifdef CDB_PERF_CNT_EN
        @(negedge clk);
        checks++;
        if (perf_grant_cnt !== 32'd4 || perf_stall_cnt !== 32'd1) begin
            failures++;
            $display("[TB] FAIL perf_counts grant=%0d stall=%0d expected 4 and 1", perf_grant_cnt, perf_stall_cnt);
        end
`endif
        // Pointer wrapped back to 0: the same pattern must repeat.
        step();
        for (int i = 0; i < 4; i++) set_req(i, 7'(8'h14 + i), 5'(14 + i), 1'b1);
        exp_q.push_back(mk(3'b111, 3'b111, 7'h14, 7'h15, 7'h16, 5'd14, 5'd15, 5'd16));
        exp_q.push_back(mk(3'b001, 3'b001, 7'h17, 7'h0, 7'h0, 5'd17, 5'd0, 5'd0));
        step();
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_nodest();
        set_req(3, 7'h33, 5'd9, 1'b0);
        set_req(0, 7'h00, 5'd4, 1'b1);
        exp_q.push_back(mk(3'b011, 3'b000, 7'h00, 7'h33, 7'h0, 5'd4, 5'd9, 5'd0));
        step();
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                set_req(1, 7'(8'h20 + i), 5'(20 + i), 1'b1);
                exp_q.push_back(mk(3'b001, 3'b001, 7'(8'h20 + i), 7'h0, 7'h0, 5'(20 + i), 5'd0, 5'd0));
            end else begin
                clear_inputs();
            end
            @(negedge clk);
            if (i < 5) begin
                checks++;
                if (req_ready[1] !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL b2b_ready cycle=%0d got=%b expected=1", i, req_ready[1]);
                end
            end
            if (i >= 2) begin
                checks++;
                if (rob_done_valid !== 3'b001) begin
                    failures++;
                    $display("[TB] FAIL b2b_gap cycle=%0d dv=%b expected=001", i, rob_done_valid);
                end
            end
            step();
        end
        @(negedge clk);
        checks++;
        if (rob_done_valid !== 3'b000) begin
            failures++;
            $display("[TB] FAIL b2b_tail dv=%b expected=000", rob_done_valid);
        end
        step();
    endtask

    task automatic test_mispredict();
        set_req(0, 7'h30, 5'd1, 1'b1);
        set_req(2, 7'h32, 5'd2, 1'b1);
        set_req(3, 7'h33, 5'd3, 1'b1);
        step();
        clear_inputs();
        mispredict = 1'b1;
        req_valid  = 4'hF;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'h0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_cycle ready=%b busy=%b expected 0000 and 1", req_ready, busy);
        end
        step();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rob_done_valid !== 3'b000) begin
            failures++;
            $display("[TB] FAIL after_flush busy=%b dv=%b expected 0 and 000", busy, rob_done_valid);
        end
        // Pointer was retained at 2, so the branch unit goes ahead of ALU1.
        set_req(1, 7'h41, 5'd17, 1'b1);
        set_req(2, 7'h42, 5'd18, 1'b1);
        exp_q.push_back(mk(3'b011, 3'b011, 7'h42, 7'h41, 7'h0, 5'd18, 5'd17, 5'd0));
        step();
        clear_inputs();
        repeat (3) step();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_four();
        test_nodest();
        test_back_to_back();
        test_mispredict();
        repeat (2) step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL missing_broadcasts pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the three Common Data Bus broadcast slots (preg1/2/3 plus valid) among NUM_REQ functional-unit completion requesters: ALU0, ALU1, branch and LSU.
- Each requester owns a one-entry holding register. Each cycle, up to 3 pending entries are granted round-robin and broadcast registered on the next cycle.
- The broadcasts drive the reservation-station wakeup, PRF ready-set and ROB completion.

Parameters:
- NUM_REQ, 4, number of completion requesters (2..8). Index 0 = ALU0, 1 = ALU1, 2 = branch, 3 = LSU.
- PREG_W, 7, physical register tag width.
- ROB_W, 5, ROB index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mispredict  in  1  global flush
- req_valid  in  NUM_REQ  requester i has a completion
- req_ready  out  NUM_REQ  holding register i can accept
- req_preg  in  NUM_REQ*PREG_W  destination preg, flattened; requester i at [i*PREG_W +: PREG_W]
- req_has_dest  in  NUM_REQ  instruction writes a register
- req_rob_tag  in  NUM_REQ*ROB_W  ROB index, flattened
- preg1_rdy, preg2_rdy, preg3_rdy  out  PREG_W  broadcast tag per slot
- preg1_valid, preg2_valid, preg3_valid  out  1  tag broadcast valid
- rob_done_valid  out  3  slot k completes a ROB entry
- rob_done_tag  out  3*ROB_W  ROB index per slot
- busy  out  1  any holding register occupied

Behaviour:
- Reset: holding registers empty; rr_ptr=0; all outputs 0; req_ready all 0 during the reset cycle.
- Accept: when req_valid[i] && req_ready[i], the holding register captures preg, has_dest and rob_tag, and occ[i] goes to 1 next cycle.
- req_ready[i] = !occ[i] || grant[i]. This allows back-to-back refill in the same cycle an entry is granted.
- Grant: scan occupied entries starting at index rr_ptr, wrapping modulo NUM_REQ. The first 3 occupied entries found are granted.
  - Slot fill order follows scan order: first grant goes to slot 1, second to slot 2, third to slot 3.
  - A granted entry clears occ unless it is refilled the same cycle.
- Latency: request accepted in cycle t → earliest broadcast in cycle t+2 (capture at t+1 edge, grant in t+1, registered output at t+2).
- Outputs are registered. For each slot k filled by grant:
  - rob_done_valid[k]=1 and rob_done_tag=entry tag.
  - pregk_valid = has_dest && preg != 0. The pregk_rdy tag is driven regardless.
- Unfilled slots: valid=0, tag fields=0.
- rr_ptr: set to (index of last granted + 1) mod NUM_REQ. Unchanged if nothing is granted.
- Fewer than 4 occupied with NUM_REQ=4: all granted in one cycle; no starvation.
- All 4 occupied: the entry at rr_ptr+3 waits exactly one cycle, and its priority is guaranteed the next cycle.
- mispredict (synchronous):
  - All occ cleared.
  - Registered slot valids and rob_done_valid go to 0 next cycle.
  - Grants in the flush cycle are discarded.
  - req_ready forced 0 for that cycle.
  - rr_ptr retained.
- reset takes precedence over mispredict.
- busy = |occ.

Optional Feature:
- CDB_PERF_CNT_EN
  - Defined: adds outputs perf_grant_cnt (32 bits) and perf_stall_cnt (32 bits).
    - perf_grant_cnt increments by the number of grants per cycle.
    - perf_stall_cnt increments once per cycle in which any occupied entry is not granted.
    - Both saturate at all-ones, clear on reset, and are unaffected by mispredict.
  - Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- types_pkg:
  - cdb_req_t struct {preg, has_dest, rob_tag}
  - constant CDB_SLOTS=3
  - requester index localparams (REQ_ALU0, REQ_ALU1, REQ_BR, REQ_LSU)
- Sub-module rr_pick3: purely combinational rotating scan over a NUM_REQ occupancy vector with an rr_ptr input.
  - Returns a grant mask, slot index per grant, and the next rr_ptr.
  - Instantiated once.

Test Plan:
- Reset, then a single request: req 2 (preg 0x15, tag 7, has_dest=1) at cycle 1 → preg1_valid=1, preg1_rdy=0x15, rob_done_tag[0]=7 at cycle 3; slots 2 and 3 invalid; rr_ptr=3.
- Four simultaneous requests with rr_ptr=0 (pregs 0x10, 0x11, 0x12, 0x13):
  - Broadcast cycle: slots = 0x10, 0x11, 0x12; req_ready[3]=0.
  - Next cycle: slot 1 = 0x13; rr_ptr wraps 3→0.
- No-dest and p0 cases: req 3 with has_dest=0 (tag 9), and req 0 with preg=0, has_dest=1 (tag 4), same cycle → rob_done_valid=2'b11 on slots 1 and 2 with tags 4 and 9; both pregk_valid=0.
- Back-to-back: req 1 held valid for 5 cycles with changing pregs 0x20..0x24 → req_ready stays 1; one broadcast per cycle, in order, no gaps after the first.
- Mispredict: 3 entries occupied, mispredict pulsed → no broadcast next cycle; busy=0; a later request still arbitrates from the retained rr_ptr.
- With CDB_PERF_CNT_EN: the 4-request scenario → perf_grant_cnt=4, perf_stall_cnt=1.
